udc_step_scheduler: RTL
=======================

UDC_STEP_SCHEDULER -- requirements
Module: udc_step_scheduler

Interface
REQ-001 The block SHALL declare parameter CNT_W, default 3, meaning the width of each requester's step-count field.
REQ-002 The block SHALL provide port clk, input, 1, the single rising-edge clock.
REQ-003 The block SHALL provide port r_n, input, 1, the reset (asynchronous, active-low).
REQ-004 The block SHALL provide ports req_a / req_b, input, 1, the move requests from requesters A and B.
REQ-005 The block SHALL provide ports dir_a / dir_b, input, 1, the move direction (1 = up, 0 = down).
REQ-006 The block SHALL provide ports cnt_a / cnt_b, input, CNT_W, the number of counter steps requested.
REQ-007 The block SHALL provide ports gnt_a / gnt_b, output, 1, a one-cycle grant pulse.
REQ-008 The block SHALL provide ports done_a / done_b, output, 1, a one-cycle completion pulse.
REQ-009 The block SHALL provide port busy, output, 1, high while an operation is in progress.
REQ-010 The block SHALL provide port u, output, 1, the direction drive to the up/down counter.
REQ-011 The block SHALL provide port step, output, 1, the counter advance enable.
REQ-012 The block SHALL provide port cr, output, 1, the counter synchronous home request.
REQ-013 The block SHALL provide port exp_code, output, 3, a mirror of the expected counter code.

Function
REQ-014 The block SHALL implement FSM states IDLE, STEP and DONE, and all outputs SHALL be registered.
REQ-015 In IDLE, if any request is high at a clock edge, the block SHALL, after that edge, pulse the winner's gnt, latch its dir and cnt, and enter STEP.
REQ-016 Arbitration SHALL be round-robin: a single request wins outright; when both requests are high, the requester not served last wins; A SHALL hold priority after reset.
REQ-017 A requester SHALL hold req, dir and cnt stable until it sees gnt; an unserved request SHALL remain pending with no timeout.
REQ-018 step SHALL be high for exactly cnt consecutive cycles, starting in the gnt cycle, with u equal to the latched dir throughout those cycles.
REQ-019 exp_code SHALL advance on every edge where step=1.
- Up order: 010, 011, 101, 100, 111, 001, 110, 000, then wraps to 010.
- Down order is the exact reverse.
REQ-020 The block SHALL pulse done for the served requester in the cycle after the last step cycle, then return to IDLE.
REQ-021 busy SHALL be high from the gnt cycle through the done cycle inclusive.
REQ-022 Requests arriving while busy SHALL be ignored until IDLE and SHALL be arbitrated at the first IDLE edge.
REQ-023 A new grant SHALL occur no earlier than the cycle after done.
REQ-024 u SHALL hold its last value when step=0; cr SHALL be 0 except as stated in REQ-029.
REQ-025 cnt = 0 without the macro: the block SHALL grant, issue no step cycles, and pulse done in the cycle after gnt.

Reset
REQ-026 When r_n=0, the block SHALL immediately force state to IDLE, exp_code to 010, the priority pointer to A, and gnt, done, busy, u, step and cr to 0.
REQ-027 A reset asserted mid-operation SHALL abandon the operation with no done pulse.
REQ-028 Reset release SHALL take effect at the first rising clk edge with r_n=1.

Configuration
REQ-029 With macro UDC_HOME_EN defined, a granted cnt = 0 request SHALL act as a home command.
- cr is high for one cycle, coincident with gnt.
- step stays 0.
- exp_code becomes 010 on that edge.
- done pulses the next cycle.
REQ-030 With UDC_HOME_EN undefined, cr SHALL be tied to 0 and cnt = 0 SHALL follow REQ-025.

Verification
REQ-031 Reset, then req_a=1, dir_a=1, cnt_a=3 -> gnt_a in cycle 1; step high for cycles 1-3 with u=1; exp_code 011, 101, 100; done_a in cycle 4; busy high for cycles 1-4.
REQ-032 From 010, req_b=1, dir_b=0, cnt_b=2 -> exp_code 000 then 110; done_b two cycles after gnt_b.
REQ-033 req_a and req_b both high from reset -> A is served first, then B is granted the cycle after done_a; on the next simultaneous request, A wins only if B was served last.
REQ-034 Up 7 steps from 010, then up 1 step -> exp_code reaches 000, then wraps to 010.
REQ-035 r_n pulled low during the step cycle of a cnt=5 operation -> outputs clear immediately, exp_code = 010, no done pulse.
REQ-036 cnt_a = 0 after exp_code = 100 -> with UDC_HOME_EN: cr pulse, exp_code 010, done_a next cycle; without: no cr, exp_code stays 100, done_a next cycle.

Source files
------------

// File: rtl/udc_step_scheduler.sv
// rtl/udc_step_scheduler.sv - two-requester round-robin step scheduler for an up/down counter
// Optional UDC_HOME_EN: a granted cnt = 0 request becomes a home command (cr pulse, code back to 010).
module udc_step_scheduler #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             r_n,
  input  logic             req_a,
  input  logic             req_b,
  input  logic             dir_a,
  input  logic             dir_b,
  input  logic [CNT_W-1:0] cnt_a,
  input  logic [CNT_W-1:0] cnt_b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             done_a,
  output logic             done_b,
  output logic             busy,
  output logic             u,
  output logic             step,
  output logic             cr,
  output logic [2:0]       exp_code
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_STEP = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] HOME_CODE = 3'b010;

  logic [1:0]       state;
  logic [CNT_W-1:0] rem;
  logic             prio_b;
  logic             owner_b;

  logic             arb_ok;
  logic             win_a;
  logic             win_b;
  logic             sel_dir;
  logic [CNT_W-1:0] sel_cnt;
  logic             home_cmd;

  // Counter code sequence going up; going down walks the same ring backwards.
  function automatic logic [2:0] code_next(input logic [2:0] c, input logic up);
    logic [2:0] n;
    n = HOME_CODE;
    if (up) begin
      case (c)
        3'b010:  n = 3'b011;
        3'b011:  n = 3'b101;
        3'b101:  n = 3'b100;
        3'b100:  n = 3'b111;
        3'b111:  n = 3'b001;
        3'b001:  n = 3'b110;
        3'b110:  n = 3'b000;
        default: n = 3'b010;
      endcase
    end else begin
      case (c)
        3'b010:  n = 3'b000;
        3'b000:  n = 3'b110;
        3'b110:  n = 3'b001;
        3'b001:  n = 3'b111;
        3'b111:  n = 3'b100;
        3'b100:  n = 3'b101;
        3'b101:  n = 3'b011;
        default: n = 3'b010;
      endcase
    end
    return n;
  endfunction

  // The done cycle also arbitrates so a pending requester is granted right after done.
  assign arb_ok  = (state == S_IDLE) || (state == S_DONE);
  assign win_a   = arb_ok && req_a && (!req_b || !prio_b);
  assign win_b   = arb_ok && req_b && !win_a;
  assign sel_dir = win_a ? dir_a : dir_b;
  assign sel_cnt = win_a ? cnt_a : cnt_b;

`ifdef UDC_HOME_EN
  assign home_cmd = (win_a || win_b) && (sel_cnt == '0);

  always_ff @(posedge clk or negedge r_n) begin
    if (!r_n) begin
      cr <= 1'b0;
    end else begin
      cr <= home_cmd;
    end
  end
`else
  assign home_cmd = 1'b0;
  assign cr       = 1'b0;
`endif

  always_ff @(posedge clk or negedge r_n) begin
    if (!r_n) begin
      state    <= S_IDLE;
      rem      <= '0;
      prio_b   <= 1'b0;
      owner_b  <= 1'b0;
      gnt_a    <= 1'b0;
      gnt_b    <= 1'b0;
      done_a   <= 1'b0;
      done_b   <= 1'b0;
      busy     <= 1'b0;
      u        <= 1'b0;
      step     <= 1'b0;
      exp_code <= HOME_CODE;
    end else begin
      gnt_a  <= 1'b0;
      gnt_b  <= 1'b0;
      done_a <= 1'b0;
      done_b <= 1'b0;
      if (step) begin
        exp_code <= code_next(exp_code, u);
      end
      case (state)
        S_IDLE, S_DONE: begin
          if (win_a || win_b) begin
            gnt_a   <= win_a;
            gnt_b   <= win_b;
            owner_b <= win_b;
            prio_b  <= win_a;
            rem     <= sel_cnt;
            busy    <= 1'b1;
            state   <= S_STEP;
            if (sel_cnt != '0) begin
              step <= 1'b1;
              u    <= sel_dir;
            end
            if (home_cmd) begin
              exp_code <= HOME_CODE;
            end
          end else begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        S_STEP: begin
          // rem counts the step cycles still owed, including the current one.
          if (rem > CNT_W'(1)) begin
            rem <= rem - CNT_W'(1);
          end else begin
            step   <= 1'b0;
            done_a <= !owner_b;
            done_b <= owner_b;
            state  <= S_DONE;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          step  <= 1'b0;
        end
      endcase
    end
  end

endmodule
